// File: rtl/spi_xfer_sequencer_if.sv
// Handshake/bus bundle between the control register block, the SPI byte engine
// and the transfer sequencer.
interface spi_xfer_sequencer_if #(
    parameter int unsigned MAX_XFERS = 16,
    parameter int unsigned N_CS      = 4,
    parameter int unsigned GUARD_W   = 4
);
    localparam int unsigned ADDR_W = $clog2(MAX_XFERS);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned SEL_W  = (N_CS > 1) ? $clog2(N_CS) : 1;

    logic               send;
    logic [CNT_W-1:0]   n_xfers;
    logic [SEL_W-1:0]   cs_sel;
    logic [GUARD_W-1:0] cs_setup;
    logic [GUARD_W-1:0] cs_hold;
    logic               abort;
    logic               eng_ready;
    logic               rx_dv;
    logic               tx_dv;
    logic [ADDR_W-1:0]  buf_addr;
    logic               rx_wr;
    logic [N_CS-1:0]    cs_n;
    logic               busy;
    logic               done;
    logic               cnt_wr;
    logic [CNT_W-1:0]   xfer_cnt;

    modport master (
        input  send, n_xfers, cs_sel, cs_setup, cs_hold, abort, eng_ready, rx_dv,
        output tx_dv, buf_addr, rx_wr, cs_n, busy, done, cnt_wr, xfer_cnt
    );

    modport slave (
        output send, n_xfers, cs_sel, cs_setup, cs_hold, abort, eng_ready, rx_dv,
        input  tx_dv, buf_addr, rx_wr, cs_n, busy, done, cnt_wr, xfer_cnt
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Sequences a burst of byte transfers through the SPI byte engine, owning the
// chip selects, setup/hold guard times, abort and the completed-transfer count.
module spi_xfer_sequencer #(
    parameter int unsigned MAX_XFERS = 16,
    parameter int unsigned N_CS      = 4,
    parameter int unsigned GUARD_W   = 4
) (
    input logic                  clk,
    input logic                  rst,
    spi_xfer_sequencer_if.master bus
);
    localparam int unsigned ADDR_W = $clog2(MAX_XFERS);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned SEL_W  = (N_CS > 1) ? $clog2(N_CS) : 1;
    localparam int unsigned GW1    = GUARD_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        LAUNCH  = 3'd2,
        WAIT_RX = 3'd3,
        HOLD    = 3'd4,
        DONE    = 3'd5,
        REARM   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [GUARD_W-1:0] setup_q, setup_d;
    logic [GUARD_W-1:0] hold_q, hold_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               abort_q, abort_d;
    logic               tx_dv_q, tx_dv_d;
    logic               rx_wr_q, rx_wr_d;
    logic [N_CS-1:0]    cs_n_q, cs_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [GW1-1:0]     guard_inc;
    logic [GW1-1:0]     guard_tgt;
    logic               guard_last;
    logic               abort_seen;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cs_active;

    // A guard of 0 still spends one cycle in SETUP/HOLD
    assign guard_inc  = {1'b0, guard_q} + GW1'(1);
    assign guard_tgt  = {1'b0, (state_q == SETUP) ? setup_q : hold_q};
    assign guard_last = (guard_inc >= guard_tgt);
    assign abort_seen = abort_q | bus.abort;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        setup_d   = setup_q;
        hold_d    = hold_q;
        guard_d   = guard_q;
        addr_d    = addr_q;
        abort_d   = abort_q;
        tx_dv_d   = 1'b0;
        rx_wr_d   = 1'b0;
        cs_n_d    = '1;
        cs_active = 1'b0;

        if (state_q != IDLE) begin
            abort_d = abort_q | bus.abort;
        end
        // Index advances the cycle after the RX write so the write sees the old address
        if (rx_wr_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    n_d     = (bus.n_xfers > CNT_W'(MAX_XFERS)) ? CNT_W'(MAX_XFERS) : bus.n_xfers;
                    sel_d   = bus.cs_sel;
                    setup_d = bus.cs_setup;
                    hold_d  = bus.cs_hold;
                    cnt_d   = '0;
                    addr_d  = '0;
                    guard_d = '0;
                    state_d = (bus.n_xfers == '0) ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (abort_seen) begin
                    guard_d = '0;
                    state_d = HOLD;
                end else if (guard_last) begin
                    state_d = LAUNCH;
                end else begin
                    guard_d = guard_q + GUARD_W'(1);
                end
            end
            LAUNCH: begin
                if (abort_seen) begin
                    guard_d = '0;
                    state_d = HOLD;
                end else if (bus.eng_ready) begin
                    tx_dv_d = 1'b1;
                    state_d = WAIT_RX;
                end
            end
            WAIT_RX: begin
                if (bus.rx_dv) begin
                    rx_wr_d = 1'b1;
                    cnt_d   = cnt_inc;
                    if ((cnt_inc >= n_q) || abort_seen) begin
                        guard_d = '0;
                        state_d = HOLD;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            HOLD: begin
                if (guard_last) begin
                    state_d = DONE;
                end else begin
                    guard_d = guard_q + GUARD_W'(1);
                end
            end
            DONE: begin
                state_d = REARM;
            end
            REARM: begin
                if (!bus.send) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            abort_d = 1'b0;
        end

        // Moore outputs are derived from the next state and registered
        cs_active = (state_d == SETUP) || (state_d == LAUNCH) ||
                    (state_d == WAIT_RX) || (state_d == HOLD);
        if (cs_active) begin
            for (int unsigned i = 0; i < N_CS; i++) begin
                if (sel_d == SEL_W'(i)) begin
                    cs_n_d[i] = 1'b0;
                end
            end
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            setup_q <= '0;
            hold_q  <= '0;
            guard_q <= '0;
            addr_q  <= '0;
            abort_q <= 1'b0;
            tx_dv_q <= 1'b0;
            rx_wr_q <= 1'b0;
            cs_n_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            setup_q <= setup_d;
            hold_q  <= hold_d;
            guard_q <= guard_d;
            addr_q  <= addr_d;
            abort_q <= abort_d;
            tx_dv_q <= tx_dv_d;
            rx_wr_q <= rx_wr_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_dv    = tx_dv_q;
    assign bus.buf_addr = addr_q;
    assign bus.rx_wr    = rx_wr_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cnt_wr   = done_q;
    assign bus.xfer_cnt = cnt_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer: directed and random bursts against a
// transaction-level model of a burst (byte count, addresses, CS, guard times).
module tb_spi_xfer_sequencer;
    localparam int unsigned MAX_XFERS = 16;
    localparam int unsigned N_CS      = 4;
    localparam int unsigned GUARD_W   = 4;
    localparam int unsigned CNT_W     = $clog2(MAX_XFERS) + 1;
    localparam int unsigned SEL_W     = $clog2(N_CS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_xfer_sequencer_if #(.MAX_XFERS(MAX_XFERS), .N_CS(N_CS), .GUARD_W(GUARD_W)) bus ();

    spi_xfer_sequencer #(.MAX_XFERS(MAX_XFERS), .N_CS(N_CS), .GUARD_W(GUARD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Byte engine model: rx_dv eng_lat cycles after tx_dv, not ready while busy or stalled
    int cyc         = 0;
    int stall_until = 0;
    int eng_lat     = 4;
    initial begin
        int  cd;
        bit  inflight;
        inflight      = 1'b0;
        cd            = 0;
        bus.rx_dv     = 1'b0;
        bus.eng_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.rx_dv = 1'b0;
            if (bus.tx_dv === 1'b1) begin
                inflight = 1'b1;
                cd       = eng_lat;
            end else if (inflight) begin
                if (cd <= 1) begin
                    bus.rx_dv = 1'b1;
                    inflight  = 1'b0;
                end else begin
                    cd--;
                end
            end
            bus.eng_ready = !inflight && (cyc >= stall_until);
        end
    end

    // Burst monitor: collects the observable transactions of one burst
    int        clr_gen = 0;
    int        tx_cnt, rx_cnt, done_cnt, cntwr_cnt, viol, pre_cs, post_cs, final_cnt;
    logic [N_CS-1:0] low_mask;
    int        addr_log[$];
    initial begin
        int        clr_seen;
        bit        seen_rx, prev_rdy, done_prev;
        logic [N_CS-1:0] low;
        clr_seen = 0;
        seen_rx = 0; prev_rdy = 1; done_prev = 0;
        tx_cnt = 0; rx_cnt = 0; done_cnt = 0; cntwr_cnt = 0; viol = 0;
        pre_cs = 0; post_cs = 0; final_cnt = 0; low_mask = '0;
        forever begin
            @(negedge clk);
            if (clr_seen != clr_gen) begin
                clr_seen = clr_gen;
                tx_cnt = 0; rx_cnt = 0; done_cnt = 0; cntwr_cnt = 0; viol = 0;
                pre_cs = 0; post_cs = 0; final_cnt = 0; low_mask = '0;
                seen_rx = 0;
                addr_log.delete();
            end
            if (rst !== 1'b1) begin
                low = ~bus.cs_n;
                if ($countones(low) > 1) viol++;
                if (low != '0 && bus.busy !== 1'b1) viol++;
                if (bus.tx_dv === 1'b1 && !prev_rdy) viol++;
                if (bus.done !== bus.cnt_wr) viol++;
                if (bus.done === 1'b1 && done_prev) viol++;
                if (low != '0) begin
                    if (tx_cnt == 0 && bus.tx_dv !== 1'b1) pre_cs++;
                    if (bus.rx_wr === 1'b1) post_cs = 1;
                    else if (seen_rx) post_cs++;
                end
                if (bus.rx_wr === 1'b1) begin
                    seen_rx = 1;
                    rx_cnt++;
                    addr_log.push_back(int'(bus.buf_addr));
                    if (bus.xfer_cnt !== CNT_W'(rx_cnt)) viol++;
                end
                if (bus.tx_dv === 1'b1) tx_cnt++;
                if (bus.done === 1'b1) begin
                    done_cnt++;
                    final_cnt = int'(bus.xfer_cnt);
                end
                if (bus.cnt_wr === 1'b1) cntwr_cnt++;
                low_mask = low_mask | low;
            end
            prev_rdy  = (bus.eng_ready === 1'b1);
            done_prev = (bus.done === 1'b1);
        end
    end

    task automatic clear_mon();
        clr_gen++;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // abort_at: -1 none, 0 during CS setup, k>0 while byte k is in flight
    task automatic run_burst(input string tag, input int n, input int sel, input int setup,
                             input int hold, input int lat, input int abort_at,
                             input int extra_send, input int stall);
        int n_eff, n_exp, budget, bad;
        bit to;
        logic [N_CS-1:0] exp_mask;
        eng_lat = lat;
        clear_mon();
        n_eff = (n > int'(MAX_XFERS)) ? int'(MAX_XFERS) : n;
        if (abort_at < 0)           n_exp = n_eff;
        else if (abort_at == 0)     n_exp = 0;
        else                        n_exp = (abort_at < n_eff) ? abort_at : n_eff;
        exp_mask = (n == 0) ? '0 : N_CS'(1 << sel);
        to = 1'b0;
        bus.n_xfers  = CNT_W'(n);
        bus.cs_sel   = SEL_W'(sel);
        bus.cs_setup = GUARD_W'(setup);
        bus.cs_hold  = GUARD_W'(hold);
        if (stall > 0) stall_until = cyc + stall;
        bus.send = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".busy_start"}, 32'(bus.busy), 32'd1);
        check({tag, ".cnt_start"}, 32'(bus.xfer_cnt), 32'd0);
        if (abort_at == 0) begin
            bus.abort = 1'b1;
            @(posedge clk);
            #1;
            bus.abort = 1'b0;
        end else if (abort_at > 0) begin
            budget = 2000;
            while (tx_cnt < abort_at && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            if (budget == 0) to = 1'b1;
            bus.abort = 1'b1;
            @(posedge clk);
            #1;
            bus.abort = 1'b0;
        end
        budget = 2000;
        while (done_cnt == 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) to = 1'b1;
        if (extra_send > 0) begin
            repeat (extra_send) @(posedge clk);
            #1;
            check({tag, ".rearm_busy"}, 32'(bus.busy), 32'd1);
            check({tag, ".rearm_done"}, 32'(done_cnt), 32'd1);
        end
        bus.send = 1'b0;
        budget = 20;
        while (bus.busy !== 1'b0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) to = 1'b1;
        repeat (lat + 3) @(posedge clk);
        #1;
        check({tag, ".timeout"}, 32'(to), 32'd0);
        check({tag, ".tx"}, 32'(tx_cnt), 32'(n_exp));
        check({tag, ".rx"}, 32'(rx_cnt), 32'(n_exp));
        bad = 0;
        foreach (addr_log[i]) if (addr_log[i] != (i % int'(MAX_XFERS))) bad++;
        check({tag, ".addr"}, 32'(bad), 32'd0);
        check({tag, ".done"}, 32'(done_cnt), 32'd1);
        check({tag, ".cnt_wr"}, 32'(cntwr_cnt), 32'd1);
        check({tag, ".final_cnt"}, 32'(final_cnt), 32'(n_exp));
        check({tag, ".cs_mask"}, 32'(low_mask), 32'(exp_mask));
        check({tag, ".protocol"}, 32'(viol), 32'd0);
        check({tag, ".cs_idle"}, 32'(bus.cs_n), 32'(N_CS'('1)));
        if (n_exp > 0 && abort_at < 0 && stall == 0)
            check({tag, ".setup"}, 32'(pre_cs), 32'(((setup > 1) ? setup : 1) + 1));
        if (stall > 0)
            check({tag, ".stall"}, 32'(pre_cs >= 10), 32'd1);
        if (n_exp > 0)
            check({tag, ".hold"}, 32'(post_cs), 32'((hold > 1) ? hold : 1));
    endtask

    initial begin
        int rn, rabort, rneff;
        rst          = 1'b1;
        bus.send     = 1'b0;
        bus.n_xfers  = '0;
        bus.cs_sel   = '0;
        bus.cs_setup = '0;
        bus.cs_hold  = '0;
        bus.abort    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.cs_n", 32'(bus.cs_n), 32'(N_CS'('1)));
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.tx_dv", 32'(bus.tx_dv), 32'd0);
        check("reset.rx_wr", 32'(bus.rx_wr), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.cnt_wr", 32'(bus.cnt_wr), 32'd0);
        check("reset.xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
        check("reset.buf_addr", 32'(bus.buf_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_burst("basic", 3, 2, 2, 1, 4, -1, 0, 0);
        run_burst("stall", 1, 0, 0, 0, 3, -1, 0, 12);
        run_burst("abort2", 8, 1, 1, 2, 4, 2, 0, 0);
        run_burst("abort_setup", 5, 3, 6, 0, 3, 0, 0, 0);
        run_burst("zero", 0, 1, 3, 3, 3, -1, 0, 0);
        run_burst("held", 2, 0, 1, 1, 2, -1, 15, 0);
        run_burst("rearm", 4, 3, 0, 3, 5, -1, 0, 0);

        // Reset while a byte is in flight
        eng_lat = 6;
        clear_mon();
        bus.n_xfers  = CNT_W'(20);
        bus.cs_sel   = SEL_W'(1);
        bus.cs_setup = GUARD_W'(1);
        bus.cs_hold  = GUARD_W'(1);
        bus.send     = 1'b1;
        begin
            int budget;
            budget = 500;
            while (tx_cnt < 2 && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            check("midrst.reach", 32'(budget > 0), 32'd1);
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        bus.send = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst.cs_n", 32'(bus.cs_n), 32'(N_CS'('1)));
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
        check("midrst.done", 32'(bus.done), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("midrst.no_done", 32'(done_cnt), 32'd0);
        check("midrst.rx_ignored", 32'(rx_cnt), 32'd1);
        check("midrst.idle_cs", 32'(bus.cs_n), 32'(N_CS'('1)));

        run_burst("sat", 20, 1, 1, 1, 2, -1, 0, 0);

        for (int k = 0; k < 10; k++) begin
            rn     = int'($urandom_range(0, 20));
            rneff  = (rn > int'(MAX_XFERS)) ? int'(MAX_XFERS) : rn;
            rabort = -1;
            if (rneff > 0 && $urandom_range(0, 3) == 0) rabort = int'($urandom_range(1, rneff));
            run_burst($sformatf("rand%0d", k), rn, int'($urandom_range(0, N_CS - 1)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(1, 6)), rabort, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
